rv_pipe_ctrl: RTL and testbench

//   Central stall/kill sequencer for the uRV fetch/decode/execute pipeline.
//   - Merges stall requests from decode, execute and data memory into per-stage stall enables.
//   - Drives decode's d_stall_i/d_kill_i and the fetch flush.
//   - Sequences branch-redirect kill windows and trap entry: drain, then flush.
//   - Flags pipeline stalls that never clear.

---
 rtl/rv_pipe_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rv_pipe_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl -- stall/kill sequencer for the uRV fetch/decode/execute pipe.
//
// Merges the stall sources into per-stage hold enables and sequences the
// two ways the front of the pipe gets thrown away:
//   * a taken branch/jump resolved in execute: flush fetch now, then keep
//     decode's output killed for KILL_CYCLES non-stalled cycles;
//   * a trap (exception or enabled interrupt): first drain any outstanding
//     data-memory access, then pulse trap entry together with the flush and
//     run the same kill window.
// A saturating counter of consecutive execute stalls raises a sticky
// timeout flag when it reaches all-ones.
//
// Ports
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   d_stall_req_i     decode load-hazard request (holds fetch only)
//   x_stall_req_i     execute multi-cycle op busy
//   w_dm_wait_i       data memory access not yet acknowledged
//   x_valid_i         execute holds a valid instruction
//   x_redirect_i      taken branch/jump in execute
//   x_exception_i     synchronous exception in execute
//   irq_i, irq_en_i   level interrupt request and global enable
//   f_stall_o         hold fetch PC/IR
//   d_stall_o         hold decode
//   x_stall_o         hold execute
//   f_flush_o         pulse: fetch drops in-flight word, takes new PC
//   d_kill_o          decode output invalid
//   trap_enter_o      pulse: CSR unit saves mepc/mcause and vectors
//   stall_timeout_o   sticky: stall lasted 2**TIMEOUT_W-1 cycles
//   state_o           debug view of the sequencer state (0 RUN, 1 KILL, 2 DRAIN)
//
// Event qualification: an execute event (redirect, exception, interrupt)
// is acted on only in a cycle where x_valid_i=1 and execute is not stalled;
// in any other cycle it is treated as absent, so the producer simply holds
// it until the stage advances.
module rv_pipe_ctrl #(
  parameter int unsigned KILL_CYCLES = 2,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       d_stall_req_i,
  input  logic       x_stall_req_i,
  input  logic       w_dm_wait_i,
  input  logic       x_valid_i,
  input  logic       x_redirect_i,
  input  logic       x_exception_i,
  input  logic       irq_i,
  input  logic       irq_en_i,
  output logic       f_stall_o,
  output logic       d_stall_o,
  output logic       x_stall_o,
  output logic       f_flush_o,
  output logic       d_kill_o,
  output logic       trap_enter_o,
  output logic       stall_timeout_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    KILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] KILL_LOAD = 3'(KILL_CYCLES - 1);
  // With a one-cycle window the flush cycle itself is the whole window.
  localparam state_t KILL_NEXT = (KILL_CYCLES == 1) ? RUN : KILL;
  localparam logic [TIMEOUT_W-1:0] SCNT_MAX = {TIMEOUT_W{1'b1}};

  state_t               state_q, state_d;
  logic [2:0]           kcnt_q, kcnt_d;
  logic [TIMEOUT_W-1:0] scnt_q, scnt_d;
  logic                 timeout_q;

  logic stall_any, qual, trap_req, redir;
  logic f_flush_c, d_kill_c, trap_c;

  assign stall_any = w_dm_wait_i | x_stall_req_i;
  assign qual      = x_valid_i & ~stall_any;
  assign trap_req  = qual & (x_exception_i | (irq_i & irq_en_i));
  assign redir     = qual & x_redirect_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RUN;
      kcnt_q    <= 3'd0;
      scnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      scnt_q    <= scnt_d;
      timeout_q <= timeout_q | (scnt_d == SCNT_MAX);
    end
  end

  // Next state and kill counter
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    case (state_q)
      RUN: begin
        if (trap_req) begin
          state_d = DRAIN;
        end else if (redir) begin
          state_d = KILL_NEXT;
          kcnt_d  = KILL_LOAD;
        end
      end
      KILL: begin
        if (redir) begin
          state_d = KILL_NEXT;
          kcnt_d  = KILL_LOAD;
        end else if (!stall_any) begin
          // The cycle that takes the count to zero is the last kill cycle.
          if (kcnt_q <= 3'd1) begin
            state_d = RUN;
            kcnt_d  = 3'd0;
          end else begin
            kcnt_d  = kcnt_q - 3'd1;
          end
        end
      end
      DRAIN: begin
        if (!w_dm_wait_i) begin
          state_d = KILL_NEXT;
          kcnt_d  = KILL_LOAD;
        end
      end
      default: begin
        state_d = RUN;
        kcnt_d  = 3'd0;
      end
    endcase
  end

  // Sequencer outputs
  always_comb begin
    f_flush_c = 1'b0;
    d_kill_c  = 1'b0;
    trap_c    = 1'b0;
    case (state_q)
      RUN: begin
        if (!trap_req && redir) begin
          f_flush_c = 1'b1;
          d_kill_c  = 1'b1;
        end
      end
      KILL: begin
        d_kill_c  = 1'b1;
        f_flush_c = redir;
      end
      DRAIN: begin
        d_kill_c  = 1'b1;
        f_flush_c = ~w_dm_wait_i;
        trap_c    = ~w_dm_wait_i;
      end
      default: begin
        d_kill_c  = 1'b0;
      end
    endcase
  end

  always_comb begin
    scnt_d = '0;
    if (stall_any) begin
      scnt_d = (scnt_q == SCNT_MAX) ? scnt_q : scnt_q + 1'b1;
    end
  end

  // Combinational outputs are gated so nothing leaks out while in reset.
  assign x_stall_o       = rst_n_i & stall_any;
  assign d_stall_o       = rst_n_i & stall_any;
  assign f_stall_o       = rst_n_i & (stall_any | d_stall_req_i | (state_q == DRAIN));
  assign f_flush_o       = rst_n_i & f_flush_c;
  assign d_kill_o        = rst_n_i & d_kill_c;
  assign trap_enter_o    = rst_n_i & trap_c;
  assign stall_timeout_o = timeout_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Testbench for rv_pipe_ctrl (KILL_CYCLES=2, TIMEOUT_W=8).
// Each directed step drives inputs just after a rising edge, pushes the
// expected {state, f_stall, d_stall, x_stall, f_flush, d_kill, trap,
// timeout} onto a queue, and pops/compares it on the falling edge.
module tb_rv_pipe_ctrl;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic d_stall_req_i, x_stall_req_i, w_dm_wait_i, x_valid_i;
  logic x_redirect_i, x_exception_i, irq_i, irq_en_i;
  logic f_stall_o, d_stall_o, x_stall_o, f_flush_o, d_kill_o;
  logic trap_enter_o, stall_timeout_o;
  logic [1:0] state_o;

  localparam logic [1:0] S_RUN = 2'd0, S_KILL = 2'd1, S_DRAIN = 2'd2;

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  rv_pipe_ctrl #(.KILL_CYCLES(2), .TIMEOUT_W(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .d_stall_req_i(d_stall_req_i), .x_stall_req_i(x_stall_req_i),
    .w_dm_wait_i(w_dm_wait_i), .x_valid_i(x_valid_i),
    .x_redirect_i(x_redirect_i), .x_exception_i(x_exception_i),
    .irq_i(irq_i), .irq_en_i(irq_en_i),
    .f_stall_o(f_stall_o), .d_stall_o(d_stall_o), .x_stall_o(x_stall_o),
    .f_flush_o(f_flush_o), .d_kill_o(d_kill_o), .trap_enter_o(trap_enter_o),
    .stall_timeout_o(stall_timeout_o), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Driver tasks
  task automatic set_in(input logic d_req, input logic x_req, input logic dm_wait,
                        input logic xv, input logic redir, input logic exc,
                        input logic irq, input logic irq_en);
    d_stall_req_i = d_req;
    x_stall_req_i = x_req;
    w_dm_wait_i   = dm_wait;
    x_valid_i     = xv;
    x_redirect_i  = redir;
    x_exception_i = exc;
    irq_i         = irq;
    irq_en_i      = irq_en;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [8:0] ex(input logic [1:0] st, input logic fs, input logic ds,
                                    input logic xs, input logic ff, input logic dk,
                                    input logic tr, input logic to);
    return {st, fs, ds, xs, ff, dk, tr, to};
  endfunction

  // Scoreboard: push expectation, compare on the falling edge, advance.
  task automatic cyc(input logic [8:0] e, input string tag);
    logic [8:0] got, want;
    exp_q.push_back(e);
    @(negedge clk_i);
    got  = {state_o, f_stall_o, d_stall_o, x_stall_o, f_flush_o, d_kill_o,
            trap_enter_o, stall_timeout_o};
    want = exp_q.pop_front();
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b (st,fs,ds,xs,ff,dk,tr,to)", tag, got, want);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(1, 4);
    idle_in();
    for (int i = 0; i < n; i++) cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "idle");
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle_in();
    @(posedge clk_i);
    #1;
    // In reset, stall sources must not reach the outputs.
    set_in(1, 1, 1, 1, 1, 1, 1, 1);
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "in_reset");
    idle_in();
    rst_n_i = 1'b1;
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "reset_release");

    // Decode hazard stalls fetch only.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(ex(S_RUN, 1, 0, 0, 0, 0, 0, 0), "d_req_stall");
    idle_in();
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "d_req_clear");
    gap();

    // Memory wait 3 cycles; a redirect under stall is not qualified.
    set_in(0, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(ex(S_RUN, 1, 1, 1, 0, 0, 0, 0), "dm_wait_stall");
    idle_in();
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "dm_wait_clear");
    gap();

    // Plain redirect: kill cycles 0-1, RUN at 2.
    set_in(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(ex(S_RUN, 0, 0, 0, 1, 1, 0, 0), "redir_c0");
    idle_in();
    cyc(ex(S_KILL, 0, 0, 0, 0, 1, 0, 0), "redir_c1");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "redir_c2");
    gap();

    // Redirect with an execute stall in cycle 1 stretches the window.
    set_in(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(ex(S_RUN, 0, 0, 0, 1, 1, 0, 0), "redir_st_c0");
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(ex(S_KILL, 1, 1, 1, 0, 1, 0, 0), "redir_st_c1");
    idle_in();
    cyc(ex(S_KILL, 0, 0, 0, 0, 1, 0, 0), "redir_st_c2");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "redir_st_c3");
    gap();

    // Re-redirect inside KILL reloads; exception inside KILL is ignored.
    set_in(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(ex(S_RUN, 0, 0, 0, 1, 1, 0, 0), "rekill_c0");
    cyc(ex(S_KILL, 0, 0, 0, 1, 1, 0, 0), "rekill_c1");
    set_in(0, 0, 0, 1, 0, 1, 1, 1);
    cyc(ex(S_KILL, 0, 0, 0, 0, 1, 0, 0), "rekill_exc_ign");
    idle_in();
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "rekill_done");
    gap();

    // Exception, memory still busy 4 cycles, then trap + flush, kill, RUN.
    set_in(0, 0, 0, 1, 0, 1, 0, 0);
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "exc_c0");
    set_in(0, 0, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) cyc(ex(S_DRAIN, 1, 1, 1, 0, 1, 0, 0), "exc_drain");
    idle_in();
    cyc(ex(S_DRAIN, 1, 0, 0, 1, 1, 1, 0), "exc_trap");
    cyc(ex(S_KILL, 0, 0, 0, 0, 1, 0, 0), "exc_kill");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "exc_run");
    gap();

    // Exception beats redirect in the same cycle.
    set_in(0, 0, 0, 1, 1, 1, 0, 0);
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "exc_redir_c0");
    idle_in();
    cyc(ex(S_DRAIN, 1, 0, 0, 1, 1, 1, 0), "exc_redir_trap");
    cyc(ex(S_KILL, 0, 0, 0, 0, 1, 0, 0), "exc_redir_kill");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "exc_redir_run");
    gap();

    // Interrupt needs enable and a valid instruction.
    set_in(0, 0, 0, 1, 0, 0, 1, 0);
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "irq_disabled");
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "irq_no_valid");
    set_in(0, 0, 0, 1, 0, 0, 1, 1);
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "irq_take");
    idle_in();
    cyc(ex(S_DRAIN, 1, 0, 0, 1, 1, 1, 0), "irq_trap");
    cyc(ex(S_KILL, 0, 0, 0, 0, 1, 0, 0), "irq_kill");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "irq_run");
    gap();

    // Long execute stall: timeout rises at cycle 255 and is sticky.
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      cyc(ex(S_RUN, 1, 1, 1, 0, 0, 0, (i >= 255) ? 1'b1 : 1'b0), "timeout_run");
    idle_in();
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 1), "timeout_sticky0");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 1), "timeout_sticky1");

    // Reset in the middle of DRAIN.
    set_in(0, 0, 0, 1, 0, 1, 0, 0);
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 1), "rst_exc_c0");
    set_in(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(ex(S_DRAIN, 1, 1, 1, 0, 1, 0, 1), "rst_drain");
    rst_n_i = 1'b0;
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "rst_mid_drain0");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "rst_mid_drain1");
    idle_in();
    rst_n_i = 1'b1;
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "rst_after");
    set_in(0, 0, 0, 1, 1, 0, 0, 0);
    cyc(ex(S_RUN, 0, 0, 0, 1, 1, 0, 0), "rst_redir_c0");
    idle_in();
    cyc(ex(S_KILL, 0, 0, 0, 0, 1, 0, 0), "rst_redir_c1");
    cyc(ex(S_RUN, 0, 0, 0, 0, 0, 0, 0), "rst_redir_c2");

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
